frog_life_ctrl: RTL

Consumes the registered `dead` collision flag from the frog/crocodile collision detector and runs the frog's life cycle. It tracks remaining lives, freezes the frog and blinks it during a death animation, and issues a respawn pulse to the frog position logic. It also declares game over. It sits between the collision detector and the frog movement/VGA sprite logic, clocked on the game clock and paced by the per-frame tick.

---
 rtl/frog_life_ctrl_if.sv | 50 +++++
 rtl/frog_life_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/frog_life_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : frog_life_ctrl_if
//  Purpose  : Signal bundle between the frame/collision/start sources and the
//             frog life-cycle controller. The "slave" side is the controller;
//             the "master" side is whatever drives the strobes and consumes
//             the life/visibility outputs.
//  Revision : 1.0  initial release
// ============================================================================
interface frog_life_ctrl_if;

    // Inputs to the controller
    logic       tick;          // one-clk frame strobe
    logic       start;         // debounced start button level
    logic       dead;          // registered collision flag

    // Outputs from the controller
    logic [2:0] lives;         // remaining lives
    logic       play;          // frog movement enable
    logic       frog_visible;  // sprite enable
    logic       respawn;       // one-clk return-to-start pulse
    logic       game_over;     // high while the game is over
    logic       invuln;        // post-respawn grace flag

    modport master (
        output tick,
        output start,
        output dead,
        input  lives,
        input  play,
        input  frog_visible,
        input  respawn,
        input  game_over,
        input  invuln
    );

    modport slave (
        input  tick,
        input  start,
        input  dead,
        output lives,
        output play,
        output frog_visible,
        output respawn,
        output game_over,
        output invuln
    );

endinterface
`default_nettype wire

// File: rtl/frog_life_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : frog_life_ctrl
//  Purpose  : Frog life cycle. Counts lives, freezes and blinks the frog for
//             a fixed death animation, pulses respawn, declares game over.
//             Every output comes straight from a register.
//  Options  : FROG_INVULN_EN - when defined, each respawn grants a grace
//             period of INVULN_FRAMES ticks during which collisions are
//             ignored. When undefined, invuln is constant 0.
//  Revision : 1.0  initial release
// ============================================================================
module frog_life_ctrl #(
    parameter int LIVES         = 3,   // 1..7
    parameter int DIE_FRAMES    = 60,  // 1..255
    parameter int BLINK_FRAMES  = 8,   // 1..255
    parameter int INVULN_FRAMES = 90   // 1..255
) (
    input  wire               clk,
    input  wire               rst_n,
    frog_life_ctrl_if.slave   bus
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter range checks
    // ------------------------------------------------------------------------
    if (LIVES < 1 || LIVES > 7) begin : g_bad_lives
        $error("frog_life_ctrl: LIVES out of range 1..7");
    end
    if (DIE_FRAMES < 1 || DIE_FRAMES > 255) begin : g_bad_die
        $error("frog_life_ctrl: DIE_FRAMES out of range 1..255");
    end
    if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_blink
        $error("frog_life_ctrl: BLINK_FRAMES out of range 1..255");
    end
    if (INVULN_FRAMES < 1 || INVULN_FRAMES > 255) begin : g_bad_invuln
        $error("frog_life_ctrl: INVULN_FRAMES out of range 1..255");
    end

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_DYING = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    localparam logic [2:0] c_lives_init  = 3'(LIVES);
    localparam logic [7:0] c_die_last    = 8'(DIE_FRAMES - 1);
    localparam logic [7:0] c_blink_last  = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0] c_invuln_last = 8'(INVULN_FRAMES - 1);

`ifdef FROG_INVULN_EN
    localparam logic c_inv_en = 1'b1;
`else
    localparam logic c_inv_en = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0] state_q,   state_d;
    logic [2:0] lives_q,   lives_d;
    logic       play_q,    play_d;
    logic       vis_q,     vis_d;
    logic       respawn_q, respawn_d;
    logic       over_q,    over_d;
    logic       invuln_q,  invuln_d;
    // frame_q times the death animation in DYING and the grace period in PLAY;
    // the two uses never overlap.
    logic [7:0] frame_q,   frame_d;
    logic [7:0] blink_q,   blink_d;

    // Two-stage start history: the rise is acted on one edge after start_q
    // captures it, giving a registered (glitch-free) start detect.
    logic       start_q;
    logic       start_prev_q;
    logic       start_rise_w;
    logic       dead_hit_w;

    assign start_rise_w = start_q & ~start_prev_q;

    // A collision only counts when no grace period is active.
    assign dead_hit_w   = bus.dead & ~invuln_q;

    // Next-state logic for the life-cycle FSM and its counters
    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        play_d    = play_q;
        vis_d     = vis_q;
        respawn_d = 1'b0;
        over_d    = over_q;
        invuln_d  = invuln_q;
        frame_d   = frame_q;
        blink_d   = blink_q;

        case (state_q)
            // Waiting for the first game, or for a new game after game over.
            // A fresh game never starts with invulnerability.
            S_IDLE, S_OVER: begin
                play_d = 1'b0;
                vis_d  = 1'b0;
                if (start_rise_w) begin
                    state_d   = S_PLAY;
                    lives_d   = c_lives_init;
                    respawn_d = 1'b1;
                    play_d    = 1'b1;
                    vis_d     = 1'b1;
                    over_d    = 1'b0;
                    invuln_d  = 1'b0;
                    frame_d   = 8'd0;
                    blink_d   = 8'd0;
                end
            end

            // Frog alive. A collision wins over a tick in the same cycle;
            // that tick is not counted toward the death animation.
            S_PLAY: begin
                if (dead_hit_w) begin
                    state_d  = S_DYING;
                    lives_d  = lives_q - 3'd1;
                    play_d   = 1'b0;
                    vis_d    = 1'b0;
                    invuln_d = 1'b0;
                    frame_d  = 8'd0;
                    blink_d  = 8'd0;
                end else if (invuln_q && bus.tick) begin
                    if (frame_q == c_invuln_last) begin
                        invuln_d = 1'b0;
                        frame_d  = 8'd0;
                    end else begin
                        frame_d  = frame_q + 8'd1;
                    end
                end
            end

            // Death animation: frozen, blinking, lasting DIE_FRAMES ticks.
            S_DYING: begin
                play_d = 1'b0;
                if (bus.tick) begin
                    if (frame_q == c_die_last) begin
                        frame_d = 8'd0;
                        blink_d = 8'd0;
                        if (lives_q == 3'd0) begin
                            state_d = S_OVER;
                            over_d  = 1'b1;
                            vis_d   = 1'b0;
                        end else begin
                            state_d   = S_PLAY;
                            respawn_d = 1'b1;
                            play_d    = 1'b1;
                            vis_d     = 1'b1;
                            invuln_d  = c_inv_en;
                        end
                    end else begin
                        frame_d = frame_q + 8'd1;
                        if (blink_q == c_blink_last) begin
                            vis_d   = ~vis_q;
                            blink_d = 8'd0;
                        end else begin
                            blink_d = blink_q + 8'd1;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops everything including a pending respawn
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            lives_q      <= 3'd0;
            play_q       <= 1'b0;
            vis_q        <= 1'b0;
            respawn_q    <= 1'b0;
            over_q       <= 1'b0;
            invuln_q     <= 1'b0;
            frame_q      <= 8'd0;
            blink_q      <= 8'd0;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            play_q       <= play_d;
            vis_q        <= vis_d;
            respawn_q    <= respawn_d;
            over_q       <= over_d;
            invuln_q     <= invuln_d;
            frame_q      <= frame_d;
            blink_q      <= blink_d;
            start_q      <= bus.start;
            start_prev_q <= start_q;
        end
    end

    assign bus.lives        = lives_q;
    assign bus.play         = play_q;
    assign bus.frog_visible = vis_q;
    assign bus.respawn      = respawn_q;
    assign bus.game_over    = over_q;
    assign bus.invuln       = invuln_q;

endmodule
`default_nettype wire
